// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR engine: walks an NTAPS-deep delay line against an external
// coefficient ROM through a shared combinational multiplier, accumulates, rescales and saturates.
module fir_mac_sequencer #(
  parameter int NTAPS     = 16,
  parameter int ADDR_W    = 4,
  parameter int ACC_W     = 24,
  parameter int OUT_SHIFT = 2
) (
  input  logic                xClk,
  input  logic                xRst,
  input  logic [15:0]         xSampleIn,
  input  logic                xSampleValid,
  output logic                xBusy,
  output logic                xOverrun,
  output logic [ADDR_W-1:0]   xCoefAddr,
  input  logic [15:0]         xCoef,
  output logic [15:0]         xMultiplicand,
  output logic [15:0]         xMultiplier,
  input  logic [15:0]         xProduct,
  output logic [15:0]         xSampleOut,
  output logic                xOutValid
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  localparam int                SH_W = ACC_W + OUT_SHIFT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NTAPS - 1);

  state_t                    state_q, state_d;
  logic signed [15:0]        delay_q [NTAPS];
  logic signed [15:0]        delay_d [NTAPS];
  logic [ADDR_W-1:0]         wp_q, wp_d;
  logic [ADDR_W-1:0]         rp_q, rp_d;
  logic [ADDR_W-1:0]         k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [15:0]        preg_q, preg_d;
  logic [15:0]               out_q, out_d;
  logic                      valid_q, valid_d;
  logic                      ovr_q, ovr_d;

  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [SH_W-1:0]    acc_ext;
  logic signed [SH_W-1:0]    acc_shifted;
  logic [15:0]               sat_val;

  // Running sum including the product registered last cycle, and its saturated rescale.
  always_comb begin
    acc_sum     = acc_q + ACC_W'(preg_q);
    acc_ext     = SH_W'(acc_sum);
    acc_shifted = acc_ext <<< OUT_SHIFT;
    if (acc_shifted > SH_W'(32'sd32767)) begin
      sat_val = 16'h7FFF;
    end else if (acc_shifted < SH_W'(-32'sd32768)) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = acc_shifted[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    k_d     = k_q;
    acc_d   = acc_q;
    preg_d  = xProduct;
    out_d   = out_q;
    valid_d = 1'b0;
    ovr_d   = xSampleValid && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (xSampleValid) begin
          delay_d[wp_q] = xSampleIn;
          rp_d          = wp_q;
          wp_d          = (wp_q == LAST) ? '0 : wp_q + 1'b1;
          acc_d         = '0;
          k_d           = '0;
          state_d       = RUN;
        end
      end
      RUN: begin
        // The first RUN cycle has no product registered yet.
        if (k_q != '0) begin
          acc_d = acc_sum;
        end
        k_d  = k_q + 1'b1;
        rp_d = (rp_q == '0) ? LAST : rp_q - 1'b1;
        if (k_q == LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        acc_d   = acc_sum;
        out_d   = sat_val;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge xClk) begin
    if (xRst) begin
      state_q <= IDLE;
      for (int i = 0; i < NTAPS; i++) begin
        delay_q[i] <= '0;
      end
      wp_q    <= '0;
      rp_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      preg_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      preg_q  <= preg_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign xBusy         = (state_q != IDLE);
  assign xOverrun      = ovr_q;
  assign xOutValid     = valid_q;
  assign xSampleOut    = out_q;
  assign xCoefAddr     = (state_q == RUN) ? k_q : '0;
  assign xMultiplicand = (state_q == RUN) ? delay_q[rp_q] : '0;
  assign xMultiplier   = (state_q == RUN) ? xCoef : '0;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: per-cycle comparison against a sample-history FIR model,
// plus hand-computed results for impulse, latency, saturation, overrun, reset and wrap cases.
module tb_fir_mac_sequencer;

  localparam int NTAPS = 16;

  logic        xClk = 1'b0;
  logic        xRst;
  logic [15:0] xSampleIn;
  logic        xSampleValid;
  logic        xBusy, xOverrun, xOutValid;
  logic [3:0]  xCoefAddr;
  logic [15:0] xCoef, xMultiplicand, xMultiplier, xProduct, xSampleOut;

  logic        s5Valid;
  logic [15:0] s5In;
  logic        busy5, ovr5, valid5;
  logic [2:0]  addr5;
  logic [15:0] coef5, mcand5, mplier5, prod5, out5;

  logic signed [15:0] coef_rom [NTAPS];
  logic signed [15:0] coef_rom5 [8];
  logic signed [31:0] prod_full, prod_sh, prod_full5, prod_sh5;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;
  logic [15:0] out_log[$];
  logic [15:0] out_log5[$];

  always #5 xClk = ~xClk;

  // Coefficient ROMs and the external multipliers (full product >>> 17).
  assign xCoef     = coef_rom[xCoefAddr];
  assign prod_full = $signed(xMultiplicand) * $signed(xMultiplier);
  assign prod_sh   = prod_full >>> 17;
  assign xProduct  = prod_sh[15:0];

  assign coef5      = coef_rom5[addr5];
  assign prod_full5 = $signed(mcand5) * $signed(mplier5);
  assign prod_sh5   = prod_full5 >>> 17;
  assign prod5      = prod_sh5[15:0];

  fir_mac_sequencer dut (
    .xClk(xClk), .xRst(xRst), .xSampleIn(xSampleIn), .xSampleValid(xSampleValid),
    .xBusy(xBusy), .xOverrun(xOverrun), .xCoefAddr(xCoefAddr), .xCoef(xCoef),
    .xMultiplicand(xMultiplicand), .xMultiplier(xMultiplier), .xProduct(xProduct),
    .xSampleOut(xSampleOut), .xOutValid(xOutValid)
  );

  fir_mac_sequencer #(.NTAPS(5), .ADDR_W(3)) dut5 (
    .xClk(xClk), .xRst(xRst), .xSampleIn(s5In), .xSampleValid(s5Valid),
    .xBusy(busy5), .xOverrun(ovr5), .xCoefAddr(addr5), .xCoef(coef5),
    .xMultiplicand(mcand5), .xMultiplier(mplier5), .xProduct(prod5),
    .xSampleOut(out5), .xOutValid(valid5)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Reference model: accepted samples newest-first, remaining busy cycles, pending result.
  logic signed [15:0] hist [NTAPS];
  int          mLeft = 0;
  logic [15:0] mOut = '0;
  logic [15:0] mPending = '0;
  logic        mOvr = 1'b0;

  always @(posedge xClk) begin
    if (xRst) begin
      mLeft = 0;
      mOut  = '0;
      mOvr  = 1'b0;
      for (int i = 0; i < NTAPS; i++) hist[i] = '0;
    end else begin
      mOvr = xSampleValid && (mLeft > 0);
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 1) mOut = mPending;
      end else if (xSampleValid) begin
        int sum;
        for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = xSampleIn;
        sum = 0;
        for (int k = 0; k < NTAPS; k++) sum += (int'(hist[k]) * int'(coef_rom[k])) >>> 17;
        sum = sum * 4;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        mPending = 16'(sum);
        mLeft = NTAPS + 2;
      end
    end
  end

  always @(negedge xClk) begin
    if (checking) begin
      int  k;
      bit  inRun;
      inRun = (mLeft >= 3);
      k = inRun ? (NTAPS + 2 - mLeft) : 0;
      checkOutput("busy", 16'(xBusy), 16'(mLeft > 0));
      checkOutput("out_valid", 16'(xOutValid), 16'(mLeft == 1));
      checkOutput("sample_out", xSampleOut, mOut);
      checkOutput("overrun", 16'(xOverrun), 16'(mOvr));
      checkOutput("coef_addr", 16'(xCoefAddr), inRun ? 16'(k) : 16'h0);
      checkOutput("multiplicand", xMultiplicand, inRun ? hist[k] : 16'h0);
      checkOutput("multiplier", xMultiplier, inRun ? coef_rom[k] : 16'h0);
    end
    if (xOutValid) out_log.push_back(xSampleOut);
    if (valid5) out_log5.push_back(out5);
  end

  task automatic tick();
    @(posedge xClk);
    #1;
  endtask

  task automatic doReset();
    xRst = 1'b1;
    tick();
    xRst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] value);
    xSampleValid = 1'b1;
    xSampleIn    = value;
    tick();
    xSampleValid = 1'b0;
    xSampleIn    = '0;
  endtask

  task automatic loadImpulseCoefs();
    for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'(16'h0100 * (k + 1));
  endtask

  task automatic checkImpulseLog(input string tag);
    checkOutput({tag, "_count"}, 16'(out_log.size()), 16'd17);
    for (int n = 0; n < 17; n++) begin
      logic [15:0] want;
      want = (n < 16) ? 16'(16'h0080 * (n + 1)) : 16'h0000;
      checkOutput($sformatf("%s_out%0d", tag, n), (n < out_log.size()) ? out_log[n] : 16'hDEAD, want);
    end
  endtask

  initial begin
    xRst = 1'b1; xSampleValid = 1'b0; xSampleIn = '0;
    s5Valid = 1'b0; s5In = '0;
    for (int k = 0; k < 8; k++) coef_rom5[k] = (k < 5) ? 16'(16'h0100 * (k + 1)) : 16'h0;
    loadImpulseCoefs();
    tick(); tick();
    xRst = 1'b0;
    checking = 1'b1;

    checkOutput("rst_sample_out", xSampleOut, 16'h0);
    checkOutput("rst_busy", 16'(xBusy), 16'h0);
    checkOutput("rst_out_valid", 16'(xOutValid), 16'h0);
    checkOutput("rst_overrun", 16'(xOverrun), 16'h0);

    // Latency: strobe in cycle T, busy from T+1, valid only at T+18, idle at T+19.
    out_log.delete();
    applyStimulus(16'h4000);
    checkOutput("lat_busy_rise", 16'(xBusy), 16'h1);
    for (int c = 2; c <= 19; c++) begin
      tick();
      checkOutput($sformatf("lat_valid_T%0d", c), 16'(xOutValid), 16'(c == 18));
      if (c == 19) checkOutput("lat_busy_fall", 16'(xBusy), 16'h0);
    end
    checkOutput("lat_result", (out_log.size() > 0) ? out_log[0] : 16'hDEAD, 16'h0080);

    // Impulse response.
    doReset();
    out_log.delete();
    for (int n = 0; n < 17; n++) begin
      applyStimulus((n == 0) ? 16'h4000 : 16'h0000);
      repeat (19) tick();
    end
    checkImpulseLog("imp");

    // Impulse with dropped strobes in RUN and in the OUT cycle.
    doReset();
    out_log.delete();
    for (int n = 0; n < 17; n++) begin
      applyStimulus((n == 0) ? 16'h4000 : 16'h0000);
      for (int c = 1; c <= 19; c++) begin
        if ((n == 0 && c == 5) || (n == 1 && c == 18)) begin
          applyStimulus(16'h1234);
          checkOutput($sformatf("ovr_pulse_%0d", n), 16'(xOverrun), 16'h1);
        end else begin
          tick();
        end
      end
    end
    checkImpulseLog("ovr");

    // Positive and negative saturation.
    for (int s = 0; s < 2; s++) begin
      doReset();
      out_log.delete();
      for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'h7FFF;
      for (int n = 0; n < 16; n++) begin
        applyStimulus((s == 0) ? 16'h7FFF : 16'h8000);
        repeat (19) tick();
      end
      checkOutput($sformatf("sat%0d_count", s), 16'(out_log.size()), 16'd16);
      checkOutput($sformatf("sat%0d_last", s), (out_log.size() > 0) ? out_log[$] : 16'hDEAD,
                  (s == 0) ? 16'h7FFF : 16'h8000);
    end

    // Reset while in RUN aborts the sample and clears the delay line.
    doReset();
    loadImpulseCoefs();
    out_log.delete();
    applyStimulus(16'h4000);
    repeat (5) tick();
    doReset();
    repeat (25) tick();
    checkOutput("rstrun_no_valid", 16'(out_log.size()), 16'h0);
    checkOutput("rstrun_sample_out", xSampleOut, 16'h0);
    coef_rom[0] = 16'h7FFF;
    applyStimulus(16'h4000);
    repeat (19) tick();
    checkOutput("rstrun_next", (out_log.size() > 0) ? out_log[0] : 16'hDEAD, 16'h3FFC);

    // Five-tap build: impulse after seven zeros exercises delay-line wrap.
    out_log5.delete();
    for (int n = 0; n < 13; n++) begin
      s5Valid = 1'b1;
      s5In    = (n == 7) ? 16'h4000 : 16'h0000;
      tick();
      s5Valid = 1'b0;
      s5In    = '0;
      repeat (9) tick();
    end
    checkOutput("wrap_count", 16'(out_log5.size()), 16'd13);
    for (int n = 0; n < 13; n++) begin
      logic [15:0] want;
      want = (n >= 7 && n <= 11) ? 16'(16'h0080 * (n - 6)) : 16'h0000;
      checkOutput($sformatf("wrap_out%0d", n), (n < out_log5.size()) ? out_log5[n] : 16'hDEAD, want);
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
